// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler that shares one CORDIC core among N_REQ channels,
// with a WAIT timeout that completes a stuck transaction as an error.
module cordic_sched #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [24*N_REQ-1:0] i_req_x,
    input  logic [24*N_REQ-1:0] i_req_y,
    input  logic [N_REQ-1:0]    i_chan_en,
    output logic [N_REQ-1:0]    o_ack,
    output logic [N_REQ-1:0]    o_rsp_valid,
    output logic [23:0]         o_rsp_angle,
    output logic [23:0]         o_rsp_mag,
    output logic                o_rsp_err,
    output logic                o_busy,
    output logic [23:0]         o_crd_x,
    output logic [23:0]         o_crd_y,
    output logic                o_crd_start,
    input  logic                i_crd_done,
    input  logic [23:0]         i_crd_angle,
    input  logic [23:0]         i_crd_magnitude
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t           r_state, w_state;
    logic [GW-1:0]    r_grant, w_grant, r_last, w_last, w_pick;
    logic [GW-1:0]    w_idx [N_REQ];
    logic [TW-1:0]    r_timer, w_timer;
    logic [N_REQ-1:0] w_elig, r_ack, w_ack, r_rsp_valid, w_rsp_valid;
    logic [23:0]      r_angle, w_angle, r_mag, w_mag, r_crd_x, w_crd_x, r_crd_y, w_crd_y;
    logic             w_hit, r_err, w_err, r_start, w_start, r_busy;

    assign w_elig = i_req & i_chan_en;

    // Walk channels starting just after the last served one; first eligible wins.
    always_comb begin
        w_hit  = 1'b0;
        w_pick = r_last;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx[i-1] = GW'((int'(r_last) + i) % N_REQ);
            if (!w_hit && w_elig[w_idx[i-1]]) begin
                w_hit  = 1'b1;
                w_pick = w_idx[i-1];
            end
        end
    end

    always_comb begin
        w_state     = r_state;
        w_grant     = r_grant;
        w_last      = r_last;
        w_timer     = r_timer;
        w_ack       = '0;
        w_rsp_valid = '0;
        w_start     = 1'b0;
        w_crd_x     = r_crd_x;
        w_crd_y     = r_crd_y;
        w_angle     = r_angle;
        w_mag       = r_mag;
        w_err       = r_err;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state = START;
                    w_grant = w_pick;
                    w_ack   = N_REQ'(1) << w_pick;
                    w_start = 1'b1;
                    w_crd_x = i_req_x[24*int'(w_pick) +: 24];
                    w_crd_y = i_req_y[24*int'(w_pick) +: 24];
                end
            end
            START: begin
                w_state = WAIT;
                w_timer = '0;
            end
            WAIT: begin
                if (i_crd_done) begin
                    w_state     = RESP;
                    w_angle     = i_crd_angle;
                    w_mag       = i_crd_magnitude;
                    w_err       = 1'b0;
                    w_rsp_valid = N_REQ'(1) << r_grant;
                end else if (r_timer == TW'(TIMEOUT)) begin
                    w_state     = RESP;
                    w_angle     = '0;
                    w_mag       = '0;
                    w_err       = 1'b1;
                    w_rsp_valid = N_REQ'(1) << r_grant;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            RESP: begin
                w_state = IDLE;
                w_last  = r_grant;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_last      <= GW'(N_REQ - 1);
            r_timer     <= '0;
            r_ack       <= '0;
            r_rsp_valid <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_crd_x     <= '0;
            r_crd_y     <= '0;
            r_angle     <= '0;
            r_mag       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_grant     <= w_grant;
            r_last      <= w_last;
            r_timer     <= w_timer;
            r_ack       <= w_ack;
            r_rsp_valid <= w_rsp_valid;
            r_start     <= w_start;
            r_busy      <= (w_state != IDLE);
            r_crd_x     <= w_crd_x;
            r_crd_y     <= w_crd_y;
            r_angle     <= w_angle;
            r_mag       <= w_mag;
            r_err       <= w_err;
        end
    end

    assign o_ack       = r_ack;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_angle = r_angle;
    assign o_rsp_mag   = r_mag;
    assign o_rsp_err   = r_err;
    assign o_busy      = r_busy;
    assign o_crd_x     = r_crd_x;
    assign o_crd_y     = r_crd_y;
    assign o_crd_start = r_start;
endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: random and directed traffic against a transaction-level model
// of the scheduler and an ideal CORDIC core with selectable latency.
module tb_cordic_sched;
    localparam int N = 3;
    localparam int T = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   en = '1;
    logic [24*N-1:0] req_x, req_y;
    logic [N-1:0]   o_ack, o_rsp_valid;
    logic [23:0]    o_rsp_angle, o_rsp_mag, o_crd_x, o_crd_y;
    logic           o_rsp_err, o_busy, o_crd_start, crd_done;
    logic [23:0]    crd_angle = '0, crd_mag = '0;

    int  total = 0, bad = 0, cyc = 0;
    bit  dead = 0, stray = 0;
    int  cnt = 0;
    int  ox[N], oy[N], want[N];
    int  sx, sy;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_ops
        assign req_x[24*k +: 24] = ox[k][23:0];
        assign req_y[24*k +: 24] = oy[k][23:0];
    end

    cordic_sched #(.N_REQ(N), .TIMEOUT(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_x(req_x), .i_req_y(req_y),
        .i_chan_en(en), .o_ack(o_ack), .o_rsp_valid(o_rsp_valid), .o_rsp_angle(o_rsp_angle),
        .o_rsp_mag(o_rsp_mag), .o_rsp_err(o_rsp_err), .o_busy(o_busy), .o_crd_x(o_crd_x),
        .o_crd_y(o_crd_y), .o_crd_start(o_crd_start), .i_crd_done(crd_done),
        .i_crd_angle(crd_angle), .i_crd_magnitude(crd_mag)
    );

    function automatic int rnd(real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    function automatic int ref_ang(int x, int y);
        if (x == 0 && y == 0) return 0;
        return rnd($atan2($itor(y), $itor(x)) * 11790.0 / 1.5707963267948966);
    endfunction

    function automatic int ref_mag(int x, int y);
        return rnd($sqrt($itor(x) * $itor(x) + $itor(y) * $itor(y)));
    endfunction

    // Ideal core: 1-cycle answer for a zero vector, 14 cycles otherwise, silent when dead.
    assign sx = int'($signed(o_crd_x));
    assign sy = int'($signed(o_crd_y));
    assign crd_done = (cnt == 1) || stray;
    always @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 0;
        end else begin
            if (cnt > 0) cnt <= cnt - 1;
            if (o_crd_start) begin
                cnt       <= dead ? 0 : ((sx == 0 && sy == 0) ? 1 : 14);
                crd_angle <= 24'(ref_ang(sx, sy));
                crd_mag   <= 24'(ref_mag(sx, sy));
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    typedef struct {int ch; int rsp_cyc; int ang; int mag; bit err;} exp_t;
    exp_t sb[$];
    int   ack_log[$];
    bit   m_busy = 0;
    int   m_g = 0, m_ack = 0, m_rsp = 0, m_last = N - 1;

    // Priority is the circular distance after the last served channel.
    function automatic int pick(logic [N-1:0] e, int last);
        int best = -1;
        int bd = N;
        for (int ch = 0; ch < N; ch++)
            if (e[ch] && (ch - last - 1 + 2*N) % N < bd) begin
                bd = (ch - last - 1 + 2*N) % N;
                best = ch;
            end
        return best;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0;
            m_last = N - 1;
            sb.delete();
        end else if (m_busy) begin
            if (cyc == m_rsp) begin
                m_busy = 0;
                m_last = m_g;
            end
        end else if ((req & en) != 0) begin
            exp_t e;
            m_g    = pick(req & en, m_last);
            m_busy = 1;
            m_ack  = cyc + 1;
            m_rsp  = cyc + (dead ? 3 + T : ((ox[m_g] == 0 && oy[m_g] == 0) ? 3 : 16));
            e.ch = m_g;
            e.rsp_cyc = m_rsp;
            e.ang = dead ? 0 : ref_ang(ox[m_g], oy[m_g]);
            e.mag = dead ? 0 : ref_mag(ox[m_g], oy[m_g]);
            e.err = dead;
            sb.push_back(e);
        end
        cyc++;
    end

    initial begin
        logic prev_rst = 1'b0;
        int ha = 0, hm = 0, he = 0;
        logic [N-1:0] exp_ack;
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                if (!prev_rst) begin ha = 0; hm = 0; he = 0; end
                exp_ack = (m_busy && cyc == m_ack) ? (N'(1) << m_g) : '0;
                chk("ack", int'(o_ack), int'(exp_ack));
                chk("crd_start", int'(o_crd_start), int'(|exp_ack));
                chk("busy", int'(o_busy), int'(m_busy));
                for (int k = 0; k < N; k++) if (o_ack[k]) ack_log.push_back(k);
                while (sb.size() > 0 && sb[0].rsp_cyc < cyc) begin
                    chk("rsp_seen", 0, 1);
                    void'(sb.pop_front());
                end
                if (o_rsp_valid != 0) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", int'(o_rsp_valid), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_chan", int'(o_rsp_valid), int'(N'(1) << e.ch));
                        chk("rsp_cycle", cyc, e.rsp_cyc);
                        chk("rsp_angle", int'($signed(o_rsp_angle)), e.ang);
                        chk("rsp_mag", int'($signed(o_rsp_mag)), e.mag);
                        chk("rsp_err", int'(o_rsp_err), int'(e.err));
                        ha = e.ang; hm = e.mag; he = int'(e.err);
                    end
                end else begin
                    chk("hold_angle", int'($signed(o_rsp_angle)), ha);
                    chk("hold_mag", int'($signed(o_rsp_mag)), hm);
                    chk("hold_err", int'(o_rsp_err), he);
                end
            end
            prev_rst = rst_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++)
            if (req[k] && o_ack[k]) begin
                want[k]--;
                if (want[k] <= 0) req[k] = 1'b0;
            end
    endtask

    task automatic req_ch(int k, int x, int y, int w);
        ox[k] = x; oy[k] = y; want[k] = w; req[k] = 1'b1;
    endtask

    function automatic int rv();
        return int'($urandom_range(0, 2097152)) - 1048576;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((req != 0 || o_busy) && n < 300) begin tick(); n++; end
        chk("idle_reached", int'(n < 300), 1);
    endtask

    task automatic wait_ack(int k);
        int n = 0;
        while (!o_ack[k] && n < 100) begin tick(); n++; end
        chk("ack_reached", int'(o_ack[k]), 1);
    endtask

    initial begin
        int rr_exp[4] = '{0, 1, 2, 0};
        int mk_exp[4] = '{0, 2, 0, 2};
        int n;
        for (int k = 0; k < N; k++) begin ox[k] = 0; oy[k] = 0; want[k] = 0; end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        req_ch(0, 32768, 0, 1);
        wait_idle();
        chk("single_angle", int'($signed(o_rsp_angle)), 0);
        chk("single_mag", int'($signed(o_rsp_mag)), 32768);
        chk("single_err", int'(o_rsp_err), 0);
        req_ch(1, 0, 0, 1);
        wait_idle();
        chk("zero_angle", int'($signed(o_rsp_angle)), 0);
        chk("zero_mag", int'($signed(o_rsp_mag)), 0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        ack_log.delete();
        req_ch(0, 20000, 20000, 2);
        req_ch(1, 20000, 20000, 1);
        req_ch(2, 20000, 20000, 1);
        wait_idle();
        chk("rr_count", ack_log.size(), 4);
        for (int i = 0; i < 4; i++) if (i < ack_log.size()) chk("rr_order", ack_log[i], rr_exp[i]);
        chk("rr_angle", int'($signed(o_rsp_angle)), 5895);
        dead = 1;
        req_ch(2, rv(), rv(), 1);
        wait_idle();
        chk("timeout_err", int'(o_rsp_err), 1);
        chk("timeout_angle", int'($signed(o_rsp_angle)), 0);
        chk("timeout_mag", int'($signed(o_rsp_mag)), 0);
        dead = 0;
        req_ch(0, 1000, -1000, 1);
        wait_idle();
        chk("after_timeout_err", int'(o_rsp_err), 0);
        req_ch(0, 30000, 5000, 1);
        wait_ack(0);
        repeat (4) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_start", int'(o_crd_start), 0);
        req_ch(2, rv(), rv(), 1);
        wait_idle();
        req_ch(2, rv(), rv(), 1);
        req_ch(0, rv(), rv(), 1);
        wait_idle();
        stray = 1'b1; tick(); stray = 1'b0;
        repeat (3) tick();
        ack_log.delete();
        en = 3'b101;
        req_ch(0, rv(), rv(), 2);
        req_ch(1, rv(), rv(), 2);
        req_ch(2, rv(), rv(), 2);
        n = 0;
        while (!(want[0] == 0 && want[2] == 0 && !o_busy) && n < 300) begin tick(); n++; end
        chk("mask_done", int'(n < 300), 1);
        chk("mask_ch1_pending", want[1], 2);
        chk("mask_count", ack_log.size(), 4);
        for (int i = 0; i < 4; i++) if (i < ack_log.size()) chk("mask_order", ack_log[i], mk_exp[i]);
        req[1] = 1'b0; want[1] = 0; en = '1;
        req_ch(1, rv(), rv(), 1);
        wait_ack(1);
        en[1] = 1'b0;
        wait_idle();
        en = '1;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 4) == 0) req_ch(k, 0, 0, 1);
                    else req_ch(k, rv(), rv(), 1);
                end else if (req[k] && $urandom_range(0, 29) == 0) begin
                    req[k] = 1'b0; want[k] = 0;
                end
            end
            if ($urandom_range(0, 19) == 0) en = N'($urandom_range(0, 7));
            if (!o_busy && $urandom_range(0, 29) == 0) dead = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
        en = '1;
        dead = 0;
        wait_idle();
        repeat (2) tick();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cordic_sched.md
CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 Parameter: N_REQ, 3, number of requesters (roll, pitch, yaw channels).
REQ-002 Parameter: TIMEOUT, 32, max WAIT cycles before error completion.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req  input  N_REQ  per-channel request level, held until ack.
REQ-007 req_x, req_y  input  24*N_REQ each  signed operands, channel k in bits [24k+23:24k], stable while req[k]=1.
REQ-008 chan_en  input  N_REQ  channel enable mask; disabled channels are never granted.
REQ-009 ack  output  N_REQ  one-cycle operand-accepted pulse.
REQ-010 rsp_valid  output  N_REQ  one-cycle result pulse to the granted channel.
REQ-011 rsp_angle, rsp_mag  output  24 each  signed result (11790 = 90 deg scale, gain-compensated magnitude).
REQ-012 rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 crd_x, crd_y  output  24 each  operands to CORDIC core.
REQ-015 crd_start  output  1  CORDIC start pulse.
REQ-016 crd_done, crd_angle, crd_magnitude  input  1/24/24  CORDIC completion pulse and results.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT, RESP; all outputs registered.
REQ-018 IDLE: if any (req & chan_en) bit set, grant g by round-robin (priority last+1, last+2, ..., last, mod N_REQ), load crd_x/crd_y from channel g, go START; else stay.
REQ-019 START (exactly one cycle): crd_start=1 and ack[g]=1; go WAIT; WAIT timer cleared.
REQ-020 crd_start and ack SHALL be 0 in every state except START.
REQ-021 WAIT: on crd_done=1 capture crd_angle/crd_magnitude into rsp_angle/rsp_mag, rsp_err=0, go RESP.
REQ-022 WAIT: otherwise timer increments; when timer reaches TIMEOUT without crd_done, rsp_angle=rsp_mag=0, rsp_err=1, go RESP.
REQ-023 crd_done outside WAIT SHALL be ignored.
REQ-024 RESP (one cycle): rsp_valid[g]=1; last<=g; go IDLE.
REQ-025 rsp_angle/rsp_mag/rsp_err SHALL hold their values until the next capture.
REQ-026 Latency, req sampled in IDLE cycle t: ack/crd_start at t+1; zero-vector operand (core done next cycle) rsp_valid at t+3; non-zero operand with 12 core iterations rsp_valid at t+16.
REQ-027 Throughput: one transaction in flight; min 4 cycles between consecutive grants.
REQ-028 Requests arriving in START/WAIT/RESP SHALL be held off and arbitrated at the next IDLE; a channel deasserting req before grant is simply not served.
REQ-029 Channel disabled via chan_en after grant SHALL still complete its transaction.
REQ-030 Requester re-asserting req in the RESP cycle is eligible in the following IDLE cycle under round-robin order.
REQ-031 Timer width SHALL hold TIMEOUT without wrap; timer saturation is not permitted to re-trigger.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force state IDLE, last=N_REQ-1 (channel 0 first), timer=0, and all outputs 0, from any state.
REQ-033 Reset mid-WAIT SHALL drop the transaction with no rsp_valid; the CORDIC core is reset by the same rst_n.

Verification
REQ-034 Single: req[0], x=32768, y=0 -> ack[0] at t+1, rsp_valid[0] at t+16, rsp_angle within 4 LSB of 0, rsp_mag within 1% of 32768, rsp_err=0.
REQ-035 Zero vector: req[1], x=0, y=0 -> rsp_valid[1] at t+3, angle=0, mag=0.
REQ-036 Round-robin: req=3'b111 held continuously after each ack re-asserted -> grant order 0,1,2,0; x=y=20000 -> angle within 4 LSB of 5895.
REQ-037 Timeout: crd_done tied 0 -> rsp_valid at t+2+TIMEOUT+1 with rsp_err=1, angle=mag=0; next request served normally.
REQ-038 Reset mid-WAIT: rst_n low 1 cycle at t+5 -> no rsp_valid, busy=0, crd_start=0; next req[2] granted before channel 0 only if channel 0 idle.
REQ-039 Mask: chan_en=3'b101, req=3'b111 -> channel 1 never acked; channels 0,2 alternate.
